noc_packet_collector: RTL

//  Parametrised sink at a router Local port. Accepts packets via the ReqUpStr/GntUpStr handshake,

---
 rtl/noc_pkg.sv | 26 ++
 rtl/collector_fifo.sv | 76 +++++++
 rtl/noc_packet_collector.sv | 139 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet collector.
// Holds the capture FSM state type, the default field widths and the default
// field offsets inside PacketIn (payload at the bottom, then sender, then packet id).
package noc_pkg;

    // Capture handshake states
    typedef enum logic {
        WAIT_REQ = 1'b0,
        GRANT    = 1'b1
    } state_e;

    localparam logic [5:0]  ROUTER_ID_DEF = 6'b001_001;
    localparam int unsigned DATA_W_DEF    = 9;
    localparam int unsigned SID_W_DEF     = 6;
    localparam int unsigned PID_W_DEF     = 10;
    localparam int unsigned PACKET_W_DEF  = 26;
    localparam int unsigned TS_W_DEF      = 16;
    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned CNT_W_DEF     = 16;

    // Default field offsets inside PacketIn
    localparam int unsigned DATA_LSB_DEF  = 0;
    localparam int unsigned SID_LSB_DEF   = DATA_W_DEF;
    localparam int unsigned PID_LSB_DEF   = DATA_W_DEF + SID_W_DEF;

endpackage

// File: rtl/collector_fifo.sv
// Synchronous first-word-fall-through FIFO used as the collector's receive buffer.
// Ports: clk/rst (async active-high), push/din write side, pop/dout read side
// (dout is the head entry), count/full/empty occupancy status.
// When empty, dout shows the most recently popped entry so the read side holds
// its last value.
module collector_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] last_ptr_c;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty = (count_q == '0);
    assign full  = (count_q == OCC_W'(DEPTH));
    assign count = count_q;

    // A push while full is accepted only when a pop frees the slot on the same edge
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);

    // Slot of the last popped entry, shown while empty
    assign last_ptr_c = rd_ptr_q - PTR_W'(1);
    assign dout       = empty ? mem_q[last_ptr_c] : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + OCC_W'(do_push_c) - OCC_W'(do_pop_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/noc_packet_collector.sv
// Packet sink at a router Local port.
// Captures PacketIn on the ReqUpStr/GntUpStr handshake, stamps it with the
// free-running cycle counter and queues it for the PE; keeps receive and
// high-water statistics.
// Ports: clk, reset (async active-high); PacketIn/ReqUpStr/GntUpStr/UpStrFull
// router side; OutValid/OutReady/OutData/OutSenderID/OutPacketID/OutArrival
// PE side; RxCount, HighWater statistics; MyID constant router position.
module noc_packet_collector import noc_pkg::*; #(
    parameter logic [5:0]  ROUTER_ID = ROUTER_ID_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned SID_W     = SID_W_DEF,
    parameter int unsigned PID_W     = PID_W_DEF,
    parameter int unsigned PACKET_W  = PACKET_W_DEF,
    parameter int unsigned TS_W      = TS_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_W-1:0]    PacketIn,
    input  logic                   ReqUpStr,
    output logic                   GntUpStr,
    output logic                   UpStrFull,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [DATA_W-1:0]      OutData,
    output logic [SID_W-1:0]       OutSenderID,
    output logic [PID_W-1:0]       OutPacketID,
    output logic [TS_W-1:0]        OutArrival,
    output logic [CNT_W-1:0]       RxCount,
    output logic [$clog2(DEPTH):0] HighWater,
    output logic [5:0]             MyID
);

    localparam int unsigned OCC_W    = $clog2(DEPTH) + 1;
    localparam int unsigned FIELDS_W = PID_W + SID_W + DATA_W;
    localparam int unsigned ENTRY_W  = FIELDS_W + TS_W;
    localparam int unsigned SID_LSB  = DATA_W;
    localparam int unsigned PID_LSB  = DATA_W + SID_W;

    state_e              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [CNT_W-1:0]    rx_q, rx_d;
    logic [OCC_W-1:0]    hw_q, hw_d;

    logic [ENTRY_W-1:0]  entry_in_c;
    logic [ENTRY_W-1:0]  head_c;
    logic [OCC_W-1:0]    occ_c;
    logic [OCC_W-1:0]    occ_next_c;
    logic                full_c;
    logic                empty_c;
    logic                push_c;
    logic                pop_c;
    logic                unused_packet_bits;

    // Spare PacketIn bits above the fields are deliberately dropped
    assign unused_packet_bits = ^PacketIn;

    assign entry_in_c = {ts_q, PacketIn[FIELDS_W-1:0]};

    // Capture only from WAIT_REQ with room; a pop on the same edge does not
    // open a slot for the router because UpStrFull is already asserted
    assign push_c     = (state_q == WAIT_REQ) & ReqUpStr & ~full_c;
    assign pop_c      = OutReady & ~empty_c;
    assign occ_next_c = occ_c + OCC_W'(push_c) - OCC_W'(pop_c);

    collector_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push_c),
        .din   (entry_in_c),
        .pop   (pop_c),
        .dout  (head_c),
        .count (occ_c),
        .full  (full_c),
        .empty (empty_c)
    );

    // Handshake FSM, cycle counter and statistics next-state
    always_comb begin
        state_d = state_q;
        gnt_d   = 1'b0;
        ts_d    = ts_q + TS_W'(1);
        rx_d    = rx_q;
        hw_d    = hw_q;
        case (state_q)
            WAIT_REQ: begin
                if (push_c) begin
                    gnt_d   = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = WAIT_REQ;
            end
            default: begin
                state_d = WAIT_REQ;
            end
        endcase
        if (push_c && (rx_q != '1)) begin
            rx_d = rx_q + CNT_W'(1);
        end
        if (occ_next_c > hw_q) begin
            hw_d = occ_next_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_REQ;
            gnt_q   <= 1'b0;
            ts_q    <= '0;
            rx_q    <= '0;
            hw_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ts_q    <= ts_d;
            rx_q    <= rx_d;
            hw_q    <= hw_d;
        end
    end

    assign GntUpStr    = gnt_q;
    assign UpStrFull   = full_c;
    assign OutValid    = ~empty_c;
    assign OutData     = head_c[DATA_W-1:0];
    assign OutSenderID = head_c[SID_LSB +: SID_W];
    assign OutPacketID = head_c[PID_LSB +: PID_W];
    assign OutArrival  = head_c[FIELDS_W +: TS_W];
    assign RxCount     = rx_q;
    assign HighWater   = hw_q;
    assign MyID        = ROUTER_ID;

endmodule
